// File: rtl/alu_add_sequencer.sv
// Sequential front-end for a 64-bit ripple-carry adder with no carry-in.
// It runs ADD/ACC in one adder pass, SUB in two passes (a + ~b, then +1), and CLR with no pass.
module alu_add_sequencer #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] add_s,
    input  logic             add_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_overflow,
    output logic [WIDTH-1:0] acc
);

    typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;
    typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_ACC = 2'b10, OP_CLR = 2'b11} op_t;

    typedef struct packed {
        op_t              op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } req_t;

    state_t           state, state_nx;
    req_t             req_r;
    logic [WIDTH-1:0] tmp_r;
    logic             accept;
    logic             sub_ovf;

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    // The adder's own overflow flag describes a + ~b + 1 split across two passes,
    // so it is wrong for SUB; derive it from the original operand signs instead.
    assign sub_ovf = (req_r.a[WIDTH-1] != req_r.b[WIDTH-1]) &&
                     (add_s[WIDTH-1] != req_r.a[WIDTH-1]);

    always_comb begin
        state_nx = state;
        add_a    = '0;
        add_b    = '0;
        case (state)
            IDLE: begin
                if (accept)
                    state_nx = (op_t'(in_op) == OP_CLR) ? DONE : PASS1;
            end
            PASS1: begin
                state_nx = DONE;
                case (req_r.op)
                    OP_SUB: begin
                        add_a    = req_r.a;
                        add_b    = ~req_r.b;
                        state_nx = PASS2;
                    end
                    OP_ACC: begin
                        add_a = acc;
                        add_b = req_r.a;
                    end
                    default: begin
                        add_a = req_r.a;
                        add_b = req_r.b;
                    end
                endcase
            end
            PASS2: begin
                add_a    = tmp_r;
                add_b    = {{(WIDTH-1){1'b0}}, 1'b1};
                state_nx = DONE;
            end
            DONE: begin
                if (out_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            req_r        <= '0;
            tmp_r        <= '0;
            out_result   <= '0;
            out_overflow <= 1'b0;
            acc          <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_r <= '{op: op_t'(in_op), a: in_a, b: in_b};
                        if (op_t'(in_op) == OP_CLR) begin
                            acc          <= '0;
                            out_result   <= '0;
                            out_overflow <= 1'b0;
                        end
                    end
                end
                PASS1: begin
                    case (req_r.op)
                        OP_SUB: tmp_r <= add_s;
                        OP_ACC: begin
                            acc          <= add_s;
                            out_result   <= add_s;
                            out_overflow <= add_ovf;
                        end
                        default: begin
                            out_result   <= add_s;
                            out_overflow <= add_ovf;
                        end
                    endcase
                end
                PASS2: begin
                    out_result   <= add_s;
                    out_overflow <= sub_ovf;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_add_sequencer.sv
// Scoreboard bench for alu_add_sequencer; the external adder is modelled here.
module tb_alu_add_sequencer;

    localparam int W = 64;
    localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, ACC = 2'b10, CLR = 2'b11;

    logic         clk = 0;
    logic         rst, in_valid, in_ready, add_ovf, out_valid, out_ready, out_overflow;
    logic [1:0]   in_op;
    logic [W-1:0] in_a, in_b, add_a, add_b, add_s, out_result, acc;

    typedef struct {
        logic [W-1:0] res;
        logic         ovf;
        logic [W-1:0] acc;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] m_acc;
    int           checks = 0, fails = 0;

    always #5 clk = ~clk;

    // external 64-bit adder: no carry-in, signed overflow out
    assign add_s   = add_a + add_b;
    assign add_ovf = (add_a[W-1] == add_b[W-1]) && (add_s[W-1] != add_a[W-1]);

    alu_add_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .add_a(add_a), .add_b(add_b), .add_s(add_s),
        .add_ovf(add_ovf), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_overflow(out_overflow), .acc(acc)
    );

    task automatic chk(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // output side: pop on each completed result handshake
    always @(negedge clk) begin
        if (!rst) begin
            chk("rdy_and_vld", {63'd0, in_ready & out_valid}, '0);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", {63'd0, out_valid}, '0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result", out_result, e.res);
                    chk("overflow", {63'd0, out_overflow}, {63'd0, e.ovf});
                    chk("acc", acc, e.acc);
                end
            end
        end
    end

    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic [W-1:0] r;
        case (op)
            ADD: begin
                r = a + b;
                e.ovf = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            SUB: begin
                r = a - b;
                e.ovf = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            ACC: begin
                r = m_acc + a;
                e.ovf = (m_acc[W-1] == a[W-1]) && (r[W-1] != m_acc[W-1]);
                m_acc = r;
            end
            default: begin
                r = '0;
                e.ovf = 1'b0;
                m_acc = '0;
            end
        endcase
        e.res = r;
        e.acc = m_acc;
        return e;
    endfunction

    // drive one request, probe adder operands, check latency, optionally stall the output
    task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
        exp_t e;
        int n, cyc, lat;
        logic [W-1:0] acc0;
        lat = (op == CLR) ? 1 : (op == SUB) ? 3 : 2;
        acc0 = m_acc;
        e = model(op, a, b);
        sb.push_back(e);
        in_op = op; in_a = a; in_b = b; in_valid = 1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n == 50) chk("in_ready_timeout", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        in_valid = 0;
        cyc = 1;
        if (op == ADD) begin
            chk("p1_add_a", add_a, a);
            chk("p1_add_b", add_b, b);
        end else if (op == SUB) begin
            chk("p1_add_a", add_a, a);
            chk("p1_add_b", add_b, ~b);
        end else if (op == ACC) begin
            chk("p1_add_a", add_a, acc0);
            chk("p1_add_b", add_b, a);
        end
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1; cyc++;
            if (op == SUB && cyc == 2) begin
                chk("p2_add_a", add_a, a + ~b);
                chk("p2_add_b", add_b, 64'd1);
            end
        end
        chk("latency", cyc, lat);
        for (int k = 0; k < hold; k++) begin
            // a competing request while the result is pending must be ignored
            in_valid = 1; in_op = CLR;
            @(posedge clk); #1;
            chk("hold_valid", {63'd0, out_valid}, 64'd1);
            chk("hold_in_ready", {63'd0, in_ready}, '0);
            chk("hold_result", out_result, e.res);
            chk("hold_acc", acc, e.acc);
        end
        in_valid = 0;
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        chk("ready_after_done", {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        rst = 1; in_valid = 0; in_op = ADD; in_a = '0; in_b = '0; out_ready = 0; m_acc = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, '0);
        chk("rst_out_valid", {63'd0, out_valid}, '0);
        chk("rst_result", out_result, '0);
        chk("rst_overflow", {63'd0, out_overflow}, '0);
        chk("rst_acc", acc, '0);
        chk("rst_add_a", add_a, '0);
        chk("rst_add_b", add_b, '0);
        rst = 0;
        @(posedge clk); #1;
        chk("post_rst_ready", {63'd0, in_ready}, 64'd1);

        send(ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0);
        send(SUB, 64'd5, 64'd3, 0);
        send(SUB, 64'h8000_0000_0000_0000, 64'd1, 0);
        send(SUB, 64'd0, 64'h8000_0000_0000_0000, 0);

        send(CLR, 64'd0, 64'd0, 0);
        send(ACC, 64'd10, 64'hDEAD, 0);
        send(ADD, 64'd1, 64'd1, 0);
        send(ACC, 64'd20, 64'd0, 0);
        send(ADD, 64'd1, 64'd1, 0);
        send(ACC, 64'hFFFF_FFFF_FFFF_FFE2, 64'd0, 0);

        for (int i = 0; i < 12; i++)
            send(2'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 2));

        send(ADD, 64'h1234, 64'h4321, 4);

        // abort a SUB in PASS2 with a nonzero accumulator
        send(ACC, 64'd5, 64'd0, 0);
        in_op = SUB; in_a = 64'd9; in_b = 64'd4; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        @(posedge clk); #1;
        chk("abort_p2_add_b", add_b, 64'd1);
        rst = 1;
        #1;
        chk("abort_rst_in_ready", {63'd0, in_ready}, '0);
        @(posedge clk); #1;
        chk("abort_out_valid", {63'd0, out_valid}, '0);
        chk("abort_acc", acc, '0);
        chk("abort_add_a", add_a, '0);
        m_acc = '0;
        rst = 0;
        #1;
        chk("abort_ready", {63'd0, in_ready}, 64'd1);
        repeat (3) begin
            @(posedge clk); #1;
            chk("abort_no_valid", {63'd0, out_valid}, '0);
        end
        send(ACC, 64'd7, 64'd0, 0);

        chk("sb_drained", sb.size(), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/alu_add_sequencer.md
# alu_add_sequencer

Sequential front-end for the team's combinational 64-bit ripple-carry adder, which has no carry-in and reports signed overflow. The block accepts operation requests over a valid/ready handshake and drives the adder's `a`/`b` operands. It captures the adder's sum and overflow, and returns a registered result over a second valid/ready handshake. Subtraction is built from two adder passes (`a + ~b`, then `+1`). A 64-bit accumulator supports running sums.

## Interface
- `WIDTH`, default 64: operand and result width. Must equal the adder width.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: request present.
- `in_ready` out 1: block can accept a request. High only in IDLE with `rst` low.
- `in_op` in 2: operation code.
  - 00 ADD, 01 SUB, 10 ACC (acc + a), 11 CLR (acc := 0).
- `in_a` in WIDTH: operand A.
- `in_b` in WIDTH: operand B. Ignored for ACC and CLR.
- `add_a` out WIDTH: operand driven to the adder `a` input.
- `add_b` out WIDTH: operand driven to the adder `b` input.
- `add_s` in WIDTH: adder sum, combinational from `add_a`/`add_b`.
- `add_ovf` in 1: adder overflow (carry[63] ^ carry[62]).
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer accepts the result.
- `out_result` out WIDTH: registered result.
- `out_overflow` out 1: registered signed-overflow flag.
- `acc` out WIDTH: current accumulator value.

## Operation
- States: IDLE, PASS1, PASS2, DONE.
- IDLE:
  - `add_a` = `add_b` = 0.
  - On `in_valid & in_ready`, latch `in_op`, `in_a`, `in_b` into `op_r`, `a_r`, `b_r`.
  - CLR: go to DONE.
  - All other ops: go to PASS1.
- PASS1:
  - ADD: `add_a` = `a_r`, `add_b` = `b_r`. Capture `add_s` → `out_result` and `add_ovf` → `out_overflow`. Go to DONE.
  - SUB: `add_a` = `a_r`, `add_b` = `~b_r`. Capture `add_s` → `tmp_r`. Go to PASS2.
  - ACC: `add_a` = `acc`, `add_b` = `a_r`. Capture `add_s` into both `out_result` and `acc`, and `add_ovf` → `out_overflow`. Go to DONE.
- PASS2 (SUB only):
  - `add_a` = `tmp_r`, `add_b` = 1.
  - Capture `add_s` → `out_result`.
  - `out_overflow` = (`a_r[63]` != `b_r[63]`) & (`add_s[63]` != `a_r[63]`). The adder's `add_ovf` is ignored for SUB in both passes.
  - Go to DONE.
- CLR path: `acc` := 0, `out_result` := 0, `out_overflow` := 0 on the IDLE→DONE transition.
- DONE:
  - `out_valid` = 1.
  - `out_result` and `out_overflow` held stable until `out_ready`.
  - On `out_ready`, go to IDLE.
- Arithmetic: all sums are modulo 2^WIDTH and the carry-out is discarded. Results wrap with no saturation.
- `acc` changes only on ACC (PASS1 capture), CLR, or reset. It is not affected by ADD or SUB.
- `in_valid` while `in_ready` = 0 is ignored; the requester must hold the request. Inputs are not sampled outside IDLE.

## Timing
- Reset (`rst` high at an edge) sets:
  - state = IDLE, `out_valid` = 0, `out_result` = 0, `out_overflow` = 0, `acc` = 0, `tmp_r` = 0, `add_a` = `add_b` = 0.
  - `in_ready` = 0 while `rst` is high, and 1 on the first cycle after `rst` is low.
- Reset mid-operation (any state): the operation is aborted and no result is produced. The accumulator is cleared even if an ACC was in flight.
- Latency from the accept edge to `out_valid` high:
  - CLR: 1 cycle.
  - ADD and ACC: 2 cycles.
  - SUB: 3 cycles.
- Throughput: one request per (latency + 1) cycles at best. `in_ready` rises the cycle after the DONE handshake.
- Accept and output do not overlap. `in_ready` and `out_valid` are never both high.
- `add_a`/`add_b` are combinational from the state and registers. The adder path must settle within one clock; the capture happens at the end of the PASS cycle.
- `out_ready` high on the first DONE cycle: `out_valid` is high for exactly that one cycle.

## Test plan
- Reset, then ADD 0x7FFF_FFFF_FFFF_FFFF + 1:
  - `out_result` = 0x8000_0000_0000_0000, `out_overflow` = 1.
  - `out_valid` high 2 cycles after accept.
- SUB 5 − 3:
  - PASS1 `add_b` = 0xFFFF_FFFF_FFFF_FFFC and `tmp_r` = 1.
  - Result 2, overflow 0, `out_valid` 3 cycles after accept.
- SUB 0x8000_0000_0000_0000 − 1 → 0x7FFF_FFFF_FFFF_FFFF, overflow 1.
- SUB 0 − 0x8000_0000_0000_0000 → 0x8000_0000_0000_0000, overflow 1.
- Sequence CLR, ACC 10, ACC 20, ACC 0xFFFF_FFFF_FFFF_FFE2:
  - `acc` = 0, then 10, then 30, then 0 (wrap).
  - Last overflow 0.
  - ADD 1+1 between the ACCs leaves `acc` unchanged.
- Backpressure and reset:
  - Hold `out_ready` low 4 cycles after an ADD. Result and overflow are held, `in_ready` stays 0, and a new `in_valid` is ignored.
  - Assert `rst` during PASS2 of a SUB. No `out_valid` is produced, `acc` = 0, and `in_ready` = 1 one cycle after `rst` falls.
